// File: rtl/ov7670_pkg.sv
// Shared types and defaults for the OV7670 frame writer slice.
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        FLUSH
    } state_t;

    localparam int unsigned H_RES_DEF = 320;
    localparam int unsigned V_RES_DEF = 240;
    localparam int unsigned PIX_W     = 16;

endpackage

// File: rtl/ov7670_frame_writer_if.sv
// Frame memory write port: valid/ready handshake with word address and data.
interface ov7670_frame_writer_if #(
    parameter int unsigned ADDR_W = 17
);
    import ov7670_pkg::*;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic              mem_ready;

    modport master (output mem_valid, output mem_addr, output mem_wdata, input mem_ready);
    modport slave  (input mem_valid, input mem_addr, input mem_wdata, output mem_ready);

endinterface

// File: rtl/ov7670_frame_writer_pixel_fifo.sv
// Small synchronous FIFO with flop storage; head entry is readable directly.
// A push and pop in the same cycle while full is accepted.
module pixel_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             one_left
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign one_left = (count == (AW+1)'(1));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign rdata    = store[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) store[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= wdata;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ov7670_frame_writer.sv
// Captures one armed frame of RGB565 pixels and writes them to frame memory.
// Each FIFO entry carries its own address so dropped pixels leave holes
// instead of shifting the rest of the frame.
// Optional: FRAME_WRITER_DOUBLE_BUFFER_EN alternates the frame base address
// and adds the front_buf output.
module ov7670_frame_writer
    import ov7670_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         vsync,
    input  logic                         pixel_valid,
    input  logic [PIX_W-1:0]             pixel_data,
    ov7670_frame_writer_if.master        mem,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overflow,
    output logic [7:0]                   frame_count
`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
    ,
    output logic                         front_buf
`endif
);
    localparam int unsigned NPIX  = H_RES * V_RES;
    localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
    localparam int unsigned ENT_W = ADDR_W + PIX_W;

    state_t            state, state_n;
    logic              vs_meta, vs_sync, vs_prev, vs_fall;
    logic [CNT_W-1:0]  pix_cnt;
    logic [ADDR_W-1:0] wr_addr, base;
    logic              push, pop, load_base, flush_done, drop;
    logic              fifo_full, fifo_empty, fifo_one_left;
    logic [ENT_W-1:0]  head;

    assign vs_fall = vs_prev & ~vs_sync;
    assign busy    = (state != IDLE);

    // vsync synchronizer plus edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_n    = state;
        push       = 1'b0;
        load_base  = 1'b0;
        flush_done = 1'b0;
        unique case (state)
            IDLE:    if (arm) state_n = WAIT_VS;
            WAIT_VS: if (vs_fall) begin
                state_n   = CAPTURE;
                load_base = 1'b1;
            end
            CAPTURE: begin
                push = pixel_valid;
                if ((pixel_valid && pix_cnt == LAST_PIX) || vs_fall) state_n = FLUSH;
            end
            FLUSH:   if (fifo_empty || (fifo_one_left && pop)) begin
                state_n    = IDLE;
                flush_done = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop  = mem.mem_valid & mem.mem_ready;
    assign drop = push & fifo_full & ~pop;

`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
    localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(NPIX);
    logic complete;

    assign base = front_buf ? FRAME_WORDS : '0;

    // Track whether the frame ran to its last pixel; only full frames flip buffers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            complete  <= 1'b0;
            front_buf <= 1'b0;
        end else begin
            if (load_base) complete <= 1'b0;
            else if (push && pix_cnt == LAST_PIX) complete <= 1'b1;
            if (flush_done && complete) front_buf <= ~front_buf;
        end
    end
`else
    assign base = '0;
`endif

    // Pixel counter, write address, status flags and frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt     <= '0;
            wr_addr     <= '0;
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= flush_done;
            if (load_base) begin
                pix_cnt <= '0;
                wr_addr <= base;
            end else if (push) begin
                pix_cnt <= pix_cnt + 1'b1;
                wr_addr <= wr_addr + 1'b1;
            end
            if (state == IDLE && arm) overflow <= 1'b0;
            else if (drop)            overflow <= 1'b1;
            if (flush_done) frame_count <= frame_count + 1'b1;
        end
    end

    pixel_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .wdata    ({wr_addr, pixel_data}),
        .rdata    (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .one_left (fifo_one_left)
    );

    assign mem.mem_valid = ~fifo_empty;
    assign mem.mem_addr  = head[ENT_W-1:PIX_W];
    assign mem.mem_wdata = head[PIX_W-1:0];

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Directed bench for ov7670_frame_writer at a 4x2 frame geometry.
module tb_ov7670_frame_writer;

    localparam int unsigned AW = 8;

    logic        clk = 1'b0;
    logic        reset, arm, vsync, pixel_valid;
    logic [15:0] pixel_data;
    logic        busy, frame_done, overflow;
    logic [7:0]  frame_count;
`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
    logic        front_buf;
    logic        exp_front = 1'b0;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned write_cnt = 0;
    int unsigned done_cnt = 0;
    logic [15:0] wr_data [256];
    logic        wr_seen [256];
    logic [AW-1:0] exp_base = '0;

    ov7670_frame_writer_if #(.ADDR_W(AW)) mif ();

    ov7670_frame_writer #(
        .H_RES      (4),
        .V_RES      (2),
        .ADDR_W     (AW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .vsync       (vsync),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .mem         (mif),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .frame_count (frame_count)
`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
        ,
        .front_buf   (front_buf)
`endif
    );

    always #5 clk = ~clk;

    // Log accepted memory writes and frame_done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (mif.mem_valid && mif.mem_ready) begin
                wr_seen[mif.mem_addr] = 1'b1;
                wr_data[mif.mem_addr] = mif.mem_wdata;
                write_cnt++;
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pixel(input logic [15:0] d);
        pixel_valid = 1'b1;
        pixel_data  = d;
        tick(1);
        pixel_valid = 1'b0;
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(4);
    endtask

    task automatic clear_log();
        for (int i = 0; i < 256; i++) begin
            wr_seen[i] = 1'b0;
            wr_data[i] = '0;
        end
        write_cnt = 0;
        done_cnt  = 0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic frame_complete(input string tag, input logic [7:0] exp_cnt);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_frame_count"}, frame_count, exp_cnt);
        check({tag, "_busy"}, busy, 0);
`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
        exp_front = ~exp_front;
        check({tag, "_front_buf"}, front_buf, exp_front);
        exp_base = exp_front ? AW'(8) : '0;
`endif
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; vsync = 1'b0;
        pixel_valid = 1'b0; pixel_data = '0; mif.mem_ready = 1'b1;
        clear_log();
        tick(3);
        check("rst_mem_valid", mif.mem_valid, 0);
        check("rst_mem_addr", mif.mem_addr, 0);
        check("rst_mem_wdata", mif.mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_count", frame_count, 0);
        reset = 1'b0;
        tick(2);

        // Pixels in IDLE and WAIT_VS are ignored, then a clean 8-pixel frame.
        send_pixel(16'hAAAA); send_pixel(16'hBBBB); tick(2);
        do_arm();
        check("arm_busy", busy, 1);
        send_pixel(16'hCCCC); send_pixel(16'hDDDD); tick(2);
        check("pre_writes", write_cnt, 0);
        check("pre_overflow", overflow, 0);
        vs_pulse();
        send_pixel(16'h0001);
        check("lat_mem_valid", mif.mem_valid, 1);
        check("lat_mem_addr", mif.mem_addr, exp_base);
        check("lat_mem_wdata", mif.mem_wdata, 16'h0001);
        for (int i = 2; i <= 8; i++) send_pixel(16'(i));
        tick(5);
        check("f1_writes", write_cnt, 8);
        for (int i = 0; i < 8; i++) check("f1_data", wr_data[exp_base + AW'(i)], 32'(i + 1));
        check("f1_overflow", overflow, 0);
        frame_complete("f1", 8'd1);

        // Memory stall of 10 cycles with pixels every 2 cycles: pixel 7 dropped.
        clear_log();
        do_arm();
        vs_pulse();
        send_pixel(16'h0011); tick(1);
        send_pixel(16'h0012); tick(1);
        mif.mem_ready = 1'b0;
        for (int i = 3; i <= 7; i++) begin
            send_pixel(16'(16'h0010 + i));
            tick(1);
        end
        check("stall_overflow", overflow, 1);
        mif.mem_ready = 1'b1;
        send_pixel(16'h0018);
        tick(10);
        check("stall_writes", write_cnt, 7);
        for (int i = 0; i < 6; i++) check("stall_data", wr_data[exp_base + AW'(i)], 32'(16'h0011 + i));
        check("stall_hole", wr_seen[exp_base + AW'(6)], 0);
        check("stall_last", wr_data[exp_base + AW'(7)], 16'h0018);
        frame_complete("f2", 8'd2);

        // Arm clears overflow; short frame ends on vsync after 5 pixels.
        clear_log();
        do_arm();
        check("arm_clr_overflow", overflow, 0);
        vs_pulse();
        for (int i = 1; i <= 5; i++) send_pixel(16'(16'h0020 + i));
        vs_pulse();
        tick(3);
        check("short_writes", write_cnt, 5);
        for (int i = 0; i < 5; i++) check("short_data", wr_data[exp_base + AW'(i)], 32'(16'h0021 + i));
        check("short_done_cnt", done_cnt, 1);
        check("short_frame_count", frame_count, 3);
        check("short_busy", busy, 0);
`ifdef FRAME_WRITER_DOUBLE_BUFFER_EN
        check("short_front_buf", front_buf, exp_front);
`endif

        // Reset during capture with a write pending.
        clear_log();
        do_arm();
        vs_pulse();
        mif.mem_ready = 1'b0;
        send_pixel(16'h0031); send_pixel(16'h0032);
        check("mid_mem_valid", mif.mem_valid, 1);
        check("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_valid", mif.mem_valid, 0);
        check("arst_mem_addr", mif.mem_addr, 0);
        check("arst_mem_wdata", mif.mem_wdata, 0);
        check("arst_busy", busy, 0);
        check("arst_frame_count", frame_count, 0);
        check("arst_overflow", overflow, 0);
        mif.mem_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
        check("arst_no_done", done_cnt, 0);
        check("arst_no_writes", write_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
